// File: rtl/stream_demux4.sv
// Registered 1-to-4 stream demultiplexer with a 2-entry FIFO per output channel.
// Optional per-channel accepted-word counters under `STREAM_DEMUX4_COUNT_EN.
module stream_demux4 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [15:0]      out_cnt0,
    output logic [15:0]      out_cnt1,
    output logic [15:0]      out_cnt2,
    output logic [15:0]      out_cnt3
);

    localparam int unsigned NCH  = 4;
    localparam int unsigned CNTW = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    occ_t             r_occ      [NCH];
    occ_t             w_occ_nxt  [NCH];
    logic [WIDTH-1:0] r_head     [NCH];
    logic [WIDTH-1:0] r_tail     [NCH];
    logic [NCH-1:0]   w_push;
    logic [NCH-1:0]   w_pop;

    // Readiness looks only at the addressed channel's registered occupancy.
    assign in_ready = (r_occ[in_sel] != ST_FULL);

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_push[k] = in_valid && in_ready && (in_sel == 2'(k));
            w_pop[k]  = (r_occ[k] != ST_EMPTY) && out_ready[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_occ_nxt[k] = r_occ[k];
            case (r_occ[k])
                ST_EMPTY: if (w_push[k]) w_occ_nxt[k] = ST_ONE;
                ST_ONE: begin
                    if (w_push[k] && !w_pop[k])      w_occ_nxt[k] = ST_FULL;
                    else if (w_pop[k] && !w_push[k]) w_occ_nxt[k] = ST_EMPTY;
                end
                ST_FULL:  if (w_pop[k]) w_occ_nxt[k] = ST_ONE;
                default:  w_occ_nxt[k] = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) r_occ[k] <= ST_EMPTY;
        end else begin
            for (int k = 0; k < NCH; k++) r_occ[k] <= w_occ_nxt[k];
        end
    end

    // Head is always the oldest word; tail is only meaningful when FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_head[k] <= '0;
                r_tail[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                case (r_occ[k])
                    ST_EMPTY: if (w_push[k]) r_head[k] <= in_data;
                    ST_ONE: begin
                        if (w_push[k] && w_pop[k]) r_head[k] <= in_data;
                        else if (w_push[k])        r_tail[k] <= in_data;
                    end
                    ST_FULL:  if (w_pop[k]) r_head[k] <= r_tail[k];
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < NCH; k++) out_valid[k] = (r_occ[k] != ST_EMPTY);
    end

    assign out_data0 = r_head[0];
    assign out_data1 = r_head[1];
    assign out_data2 = r_head[2];
    assign out_data3 = r_head[3];

`ifdef STREAM_DEMUX4_COUNT_EN
    logic [CNTW-1:0] r_cnt [NCH];

    // Saturating push counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_push[k] && (r_cnt[k] != {CNTW{1'b1}}))
                    r_cnt[k] <= r_cnt[k] + CNTW'(1);
            end
        end
    end

    assign out_cnt0 = r_cnt[0];
    assign out_cnt1 = r_cnt[1];
    assign out_cnt2 = r_cnt[2];
    assign out_cnt3 = r_cnt[3];
`else
    assign out_cnt0 = CNTW'(0);
    assign out_cnt1 = CNTW'(0);
    assign out_cnt2 = CNTW'(0);
    assign out_cnt3 = CNTW'(0);
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: per-channel FIFO model plus directed scenarios.
module tb_stream_demux4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [15:0] out_cnt0, out_cnt1, out_cnt2, out_cnt3;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    stream_demux4 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .out_cnt0(out_cnt0), .out_cnt1(out_cnt1), .out_cnt2(out_cnt2), .out_cnt3(out_cnt3)
    );

    always #5 clk = ~clk;

    // Model: each channel is a list of up to two words, oldest first.
    logic [31:0] mq   [4][2];
    int          mocc [4];
    logic [15:0] mcnt [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            mocc[k] = 0;
            mcnt[k] = '0;
            mq[k][0] = '0;
            mq[k][1] = '0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mocc[k] = 0;
                mcnt[k] = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                bit p, q;
                p = in_valid && (int'(in_sel) == k) && (mocc[k] < 2);
                q = (mocc[k] > 0) && out_ready[k];
                if (q) begin
                    mq[k][0] = mq[k][1];
                    mocc[k]  = mocc[k] - 1;
                end
                if (p) begin
                    mq[k][mocc[k]] = in_data;
                    mocc[k] = mocc[k] + 1;
`ifdef STREAM_DEMUX4_COUNT_EN
                    if (mcnt[k] != 16'hFFFF) mcnt[k] = mcnt[k] + 16'd1;
`endif
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_data(input int k);
        case (k)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic logic [15:0] dut_cnt(input int k);
        case (k)
            0: return out_cnt0;
            1: return out_cnt1;
            2: return out_cnt2;
            default: return out_cnt3;
        endcase
    endfunction

    // Compare DUT to the model on every falling edge once reset has taken effect.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(mocc[k] > 0));
                if (mocc[k] > 0) chk($sformatf("data%0d", k), dut_data(k), mq[k][0]);
                chk($sformatf("cnt%0d", k), 32'(dut_cnt(k)), 32'(mcnt[k]));
            end
            chk("in_ready", 32'(in_ready), 32'(mocc[in_sel] < 2));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc();
        check_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_data2", out_data2, 32'h0);

        // Single word to channel 2, 1-cycle latency, drained next cycle
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
        cyc();
        in_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'h4);
        chk("t1_data2", out_data2, 32'hDEADBEEF);
        cyc();
        chk("t1_drained", 32'(out_valid), 32'h0);

        // Channel 1 fills to two words, third is back-pressured
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1;
        cyc();
        in_data = 32'h2;
        cyc();
        in_data = 32'h3;
        #1;
        chk("t2_full_ready", 32'(in_ready), 32'h0);
        chk("t2_head1", out_data1, 32'h1);
        cyc();
        chk("t2_still_full", 32'(in_ready), 32'h0);
        out_ready[1] = 1'b1;
        cyc();
        chk("t2_head2", out_data1, 32'h2);
        chk("t2_ready_after_pop", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        chk("t2_head3", out_data1, 32'h3);
        cyc();
        chk("t2_empty", 32'(out_valid[1]), 32'h0);

        // Channel 0 full and stalled does not block channel 3
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hA0;
        cyc();
        in_data = 32'hA1;
        cyc();
        #1;
        chk("t3_ch0_blocked", 32'(in_ready), 32'h0);
        in_sel = 2'd3; in_data = 32'hC3;
        #1;
        chk("t3_ch3_ready", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        chk("t3_valid", 32'(out_valid), 32'h9);
        chk("t3_data3", out_data3, 32'hC3);
        chk("t3_data0", out_data0, 32'hA0);

        // Channel 2 in ONE with head A; push B while popping A
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hA;
        cyc();
        in_data = 32'hB; out_ready[2] = 1'b1;
        cyc();
        in_valid = 1'b0; out_ready[2] = 1'b0;
        chk("t4_head_b", out_data2, 32'hB);
        cyc();
        chk("t4_still_one", 32'(out_valid), 32'hD);

        // Mixed traffic on all channels with varying consumer stalls
        for (int i = 0; i < 64; i++) begin
            in_valid  = (i % 5) != 4;
            in_sel    = 2'(i * 3);
            in_data   = 32'h1000 + 32'(i);
            out_ready = 4'((i * 7) ^ (i >> 2));
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 4'h0;
        cyc();

        // Reset while holding data
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h55;
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_cnt", 32'(out_cnt0 | out_cnt1 | out_cnt2 | out_cnt3), 32'h0);

        // Saturation run on channel 0
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 2'd0;
        for (int i = 0; i < 65540; i++) begin
            in_data = 32'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
`ifdef STREAM_DEMUX4_COUNT_EN
        chk("t6_cnt0", 32'(out_cnt0), 32'hFFFF);
`else
        chk("t6_cnt0", 32'(out_cnt0), 32'h0);
`endif
        chk("t6_cnt1", 32'(out_cnt1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux4.md
# stream_demux4

Registered 1-to-4 stream demultiplexer. It is the write-side counterpart of the 4:1 `sel`-driven output mux: a single valid/ready input stream carries a 2-bit `sel` per word, and each word is steered into one of four independent output channels. Every output channel has its own 2-entry FIFO, so a stalled consumer blocks only words addressed to that channel. The block sits between a shared producer and four per-lane consumers in the datapath.

## Interface
- `WIDTH`, default 32: data width of the input and each output channel.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input word present.
- `in_ready` output 1: input word accepted this cycle when high together with `in_valid`.
- `in_data` input WIDTH: input word.
- `in_sel` input 2: destination channel, 2'b00..2'b11 selects channels 0..3.
- `out_valid` output 4: bit k high when channel k head entry is valid.
- `out_ready` input 4: bit k high when consumer k takes the head entry.
- `out_data0`..`out_data3` output WIDTH each: head entry of channel k.
- `out_cnt0`..`out_cnt3` output 16 each: accepted-word counters (see Configuration).

## Operation
- Each channel k is a 2-entry FIFO with occupancy state EMPTY, ONE or FULL.
- `in_ready` = (occupancy of channel `in_sel` != FULL). It is combinational from `in_sel` and registered state only, and never depends on `in_valid` or `out_ready`.
- Push: `in_valid && in_ready` writes `in_data` into channel `in_sel`. No other channel changes.
- Pop: `out_valid[k] && out_ready[k]` removes the channel k head. All four channels may pop in the same cycle.
- State transitions for channel k, with p = push to k and q = pop from k:
  - EMPTY: p goes to ONE; otherwise stays EMPTY. A pop cannot occur.
  - ONE: p with no q goes to FULL. q with no p goes to EMPTY. p and q together stay ONE, and the new word becomes the head.
  - FULL: p is impossible because `in_ready` is 0. q goes to ONE, and the second entry becomes the head.
- `out_valid[k]` = (occupancy != EMPTY). `out_dataK` is the head entry and is held stable while `out_valid[k] && !out_ready[k]`.
- Ordering: words to the same channel leave in acceptance order. There is no ordering relation between channels.
- `out_ready[k]` while `out_valid[k]`=0 has no effect.
- Reset: all channels go to EMPTY. `out_valid`=4'b0000, `out_data0..3`=0, `out_cntK`=0. `in_ready` therefore reads 1 in the first cycle after reset.
- Reset mid-operation discards all buffered words. Reset overrides any push or pop in the same cycle.

## Timing
- Latency: a word accepted at edge N appears on `out_valid[k]`/`out_dataK` after edge N, i.e. one cycle later.
- Throughput: one word per cycle into any channel. A channel sustains 1 word/cycle with `out_ready[k]` held high.
- A channel with `out_ready[k]`=0 accepts exactly 2 words and then deasserts `in_ready` whenever `in_sel`=k.
- There is no combinational path from `out_ready` to `in_ready` or `out_valid`.

## Configuration
- `STREAM_DEMUX4_COUNT_EN` defined:
  - `out_cntK` increments by 1 on every push to channel k.
  - It saturates at 16'hFFFF and does not wrap.
  - It resets to 0.
- Not defined: counters are not built, and `out_cnt0..3` are tied to 16'h0000. Datapath behaviour is identical.

## Test plan
- Reset, then `in_sel`=2, `in_data`=32'hDEADBEEF for 1 cycle with all `out_ready`=1 -> `out_valid`=4'b0100 and `out_data2`=32'hDEADBEEF one cycle later. `out_valid` returns to 0 the following cycle.
- `out_ready`=0; push 32'h1, 32'h2, 32'h3 to channel 1 on consecutive cycles -> first two accepted; `in_ready`=0 on the third. Then raise `out_ready[1]` -> `out_data1` reads 1 then 2. Word 3 is accepted after the first pop.
- Channel 0 FULL and stalled; `in_sel`=3 -> `in_ready`=1 and channel 3 receives the word, showing no head-of-line blocking.
- Channel 2 in ONE with head 32'hA; push 32'hB while popping -> stays ONE and next head is 32'hB.
- Assert `rst` for 1 cycle while channels hold data -> `out_valid`=0 and all `out_cntK`=0 after the edge.
- With `STREAM_DEMUX4_COUNT_EN`, push 65540 words to channel 0 -> `out_cnt0`=16'hFFFF. Without the macro -> `out_cnt0` stays 0.
